degamma_lut_update_arb: RTL and testbench
=========================================

# degamma_lut_update_arb

Schedules host writes into the degamma LUT RAM so that table updates land only during vertical blanking, never while pixels are being read. It sits between the register/host bus and the write port of the per-channel degamma LUT, sharing the LUT between host and pixel pipe by time-slot. Host writes queue in a FIFO during active video and drain one entry per clock once vsync asserts.

## Interface
- `DW`, 8: pixel/LUT address width (LUT depth 2^DW).
- `LW`, 12: LUT entry data width.
- `FIFO_DEPTH`, 16: host write queue depth (power of 2, ≥2).
- `clk`  in  1: pixel clock, single clock domain.
- `rstn`  in  1: asynchronous active-low reset.
- `vsync`  in  1: vertical blanking, high = blank; synchronous to `clk`.
- `de`  in  1: data enable; high = active pixel.
- `host_wr_valid`  in  1: host write request.
- `host_wr_ready`  out  1: queue can accept.
- `host_wr_chan`  in  2: 0=R, 1=G, 2=B, 3=reserved.
- `host_wr_addr`  in  DW: LUT index.
- `host_wr_data`  in  LW: LUT value.
- `lut_we`  out  1: LUT write strobe.
- `lut_wchan`  out  2, `lut_waddr`  out  DW, `lut_wdata`  out  LW: LUT write bus.
- `pending`  out  $clog2(FIFO_DEPTH)+1: entries queued.
- `update_done`  out  1: one-cycle pulse, blank drain completed.
- `ovf`  out  1: sticky, valid dropped while full.
- `bad_chan`  out  1: sticky, chan 3 entry discarded.
- `err_clr`  in  1: clears `ovf` and `bad_chan`.

## Operation
- FIFO: push when `host_wr_valid && host_wr_ready`; `host_wr_ready = !full` (no bypass when full, even if popping). Simultaneous push/pop leaves `pending` unchanged.
- `host_wr_valid && !host_wr_ready` sets `ovf`; the request is not queued. `err_clr` takes priority over a same-cycle set.
- `pop = (state==DRAIN) && vsync && !de && !empty`.
- `lut_we = pop` for chan 0..2. `lut_wchan/addr/wdata` = FIFO head, valid in any cycle.
- A popped chan-3 entry: `lut_we` stays 0, `bad_chan` set, entry discarded.
- `vsync_d` registers `vsync`; `rise = vsync && !vsync_d`.
- FSM states ACTIVE, DRAIN, DONE:
  - ACTIVE: on `rise` -> DRAIN; clear `wrote` flag.
  - DRAIN: each pop sets `wrote`. If `!vsync` -> ACTIVE, remaining entries wait for next blank and no `update_done`. Else if `empty` -> DONE, pulse `update_done` next cycle iff `wrote`.
  - DONE: if `!vsync` -> ACTIVE; else if `!empty` (late host write) -> DRAIN, keeping `wrote`.
- `de` high inside blank (illegal timing) stalls pops; the FSM does not change state.
- Reset mid-drain discards all queued entries; no partial-entry write occurs because `lut_we` is combinational from the FIFO head.

## Timing
- Reset: FIFO empty, `pending`=0, `host_wr_ready`=1, state ACTIVE, `vsync_d`=0, `lut_we`=0, `update_done`=0, `ovf`=0, `bad_chan`=0.
- A push at edge t can be popped in cycle t+1 at the earliest, if DRAIN.
- The first pop occurs in the cycle after the `rise` cycle (FSM enters DRAIN on the `rise` edge). Throughput is then one entry per clock.
- `lut_we` is never high in a cycle where `vsync`=0 or `de`=1.
- `update_done` asserts in the cycle after the FSM enters DONE; its width is exactly 1 cycle.
- Pointer wrap: the FIFO is a circular buffer with an extra wrap bit. Full is indicated by `pending==FIFO_DEPTH`.

## Test plan
- Queue 3 writes (R@0x10=0x123, G@0x20=0x456, B@0xFF=0xFFF) while vsync=0, then raise vsync for 10 cycles -> `lut_we` high in cycles 1-3 after rise with exactly those values in order; `update_done` pulses at cycle 5; `pending` returns to 0.
- Push 17 writes with DEPTH=16 during active video -> the 17th sees `host_wr_ready`=0 and `ovf`=1; `err_clr` clears it. Exactly 16 entries drain next blank.
- Queue 16 entries with a blank lasting 5 cycles -> 4 writes, then FSM returns to ACTIVE with `pending`=12 and no `update_done`. The next blank drains the remaining 12 and pulses `update_done`.
- Queue a chan-3 entry between two valid entries -> 2 `lut_we` strobes, `bad_chan`=1, `pending`=0.
- Push during DONE while vsync=1 -> return to DRAIN, entry written next cycle, second `update_done` pulse.
- Assert rstn=0 mid-drain with 8 pending -> immediately `pending`=0, `lut_we`=0, `host_wr_ready`=1; after release, no writes until next `rise`.

Source files
------------

// File: rtl/degamma_lut_update_arb.sv
// Host write queue for the degamma LUT: buffers host writes during active video
// and drains them into the LUT write port one per clock during vertical blanking.
module degamma_lut_update_arb #(
  parameter int DW         = 8,
  parameter int LW         = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          vsync,
  input  logic                          de,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [1:0]                    host_wr_chan,
  input  logic [DW-1:0]                 host_wr_addr,
  input  logic [LW-1:0]                 host_wr_data,
  output logic                          lut_we,
  output logic [1:0]                    lut_wchan,
  output logic [DW-1:0]                 lut_waddr,
  output logic [LW-1:0]                 lut_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          update_done,
  output logic                          ovf,
  output logic                          bad_chan,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 + DW + LW;

  typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   head;
  logic            vsync_d_q;
  logic            wrote_q, wrote_d;
  logic            update_done_q, update_done_d;
  logic            ovf_q, ovf_d;
  logic            bad_chan_q, bad_chan_d;
  logic            full, empty, push, pop, rise, head_bad;

  // Pointers carry an extra wrap bit, so their difference is the occupancy.
  assign pending       = wr_ptr_q - rd_ptr_q;
  assign full          = (pending == (AW+1)'(FIFO_DEPTH));
  assign empty         = (pending == '0);
  assign host_wr_ready = !full;
  assign push          = host_wr_valid && host_wr_ready;
  assign pop           = (state_q == DRAIN) && vsync && !de && !empty;
  assign rise          = vsync && !vsync_d_q;

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign lut_wchan = head[EW-1 -: 2];
  assign lut_waddr = head[LW +: DW];
  assign lut_wdata = head[LW-1:0];
  assign head_bad  = (lut_wchan == 2'd3);
  assign lut_we    = pop && !head_bad;

  assign update_done = update_done_q;
  assign ovf         = ovf_q;
  assign bad_chan    = bad_chan_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {host_wr_chan, host_wr_addr, host_wr_data};
  end

  always_comb begin
    state_d       = state_q;
    wrote_d       = wrote_q || pop;
    update_done_d = 1'b0;
    ovf_d         = err_clr ? 1'b0 : (ovf_q || (host_wr_valid && !host_wr_ready));
    bad_chan_d    = err_clr ? 1'b0 : (bad_chan_q || (pop && head_bad));
    // A high de inside blank is illegal timing: hold the drain where it is.
    case (state_q)
      ACTIVE: begin
        if (rise) begin
          state_d = DRAIN;
          wrote_d = 1'b0;
        end
      end
      DRAIN: begin
        if (!vsync) begin
          state_d = ACTIVE;
        end else if (!de && empty) begin
          state_d       = DONE;
          update_done_d = wrote_q;
        end
      end
      DONE: begin
        if (!vsync) state_d = ACTIVE;
        else if (!de && !empty) state_d = DRAIN;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ACTIVE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      vsync_d_q     <= 1'b0;
      wrote_q       <= 1'b0;
      update_done_q <= 1'b0;
      ovf_q         <= 1'b0;
      bad_chan_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_d_q     <= vsync;
      wrote_q       <= wrote_d;
      update_done_q <= update_done_d;
      ovf_q         <= ovf_d;
      bad_chan_q    <= bad_chan_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_degamma_lut_update_arb.sv
// Scoreboard bench for degamma_lut_update_arb: queued host writes must reach the
// LUT write port in order, only during blanking, with correct status flags.
module tb_degamma_lut_update_arb;

  logic        clk = 1'b0;
  logic        rstn, vsync, de, host_wr_valid, host_wr_ready;
  logic [1:0]  host_wr_chan, lut_wchan;
  logic [7:0]  host_wr_addr, lut_waddr;
  logic [11:0] host_wr_data, lut_wdata;
  logic        lut_we, update_done, ovf, bad_chan, err_clr;
  logic [4:0]  pending;

  int nchk = 0;
  int nerr = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  logic [21:0] sb [$];

  degamma_lut_update_arb #(.DW(8), .LW(12), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .vsync(vsync), .de(de),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_chan(host_wr_chan), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .lut_we(lut_we), .lut_wchan(lut_wchan), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pending(pending), .update_done(update_done), .ovf(ovf), .bad_chan(bad_chan),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every LUT strobe must be legal in time and match the oldest expected entry.
  always @(negedge clk) begin
    if (rstn) begin
      if (lut_we) begin
        we_cnt++;
        chk("we_gate", {30'd0, vsync, de}, 32'd2);
        if (sb.size() == 0) chk("sb_extra_write", 32'd1, 32'd0);
        else chk("lut_wr", {10'd0, lut_wchan, lut_waddr, lut_wdata}, {10'd0, sb.pop_front()});
      end
      if (update_done) done_cnt++;
    end
  end

  task automatic host_push(input logic [1:0] c, input logic [7:0] a, input logic [11:0] d,
                           input bit exp_acc);
    @(posedge clk); #1;
    host_wr_valid = 1'b1; host_wr_chan = c; host_wr_addr = a; host_wr_data = d;
    @(negedge clk);
    chk("ready", {31'd0, host_wr_ready}, {31'd0, exp_acc});
    if (exp_acc && c != 2'd3) sb.push_back({c, a, d});
    @(posedge clk); #1;
    host_wr_valid = 1'b0;
  endtask

  task automatic blank(input int n);
    @(posedge clk); #1 vsync = 1'b1;
    repeat (n) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    we_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    rstn = 1'b0; vsync = 1'b0; de = 1'b0; host_wr_valid = 1'b0;
    host_wr_chan = '0; host_wr_addr = '0; host_wr_data = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending", {27'd0, pending}, 32'd0);
    chk("rst_ready", {31'd0, host_wr_ready}, 32'd1);
    chk("rst_we", {31'd0, lut_we}, 32'd0);
    chk("rst_flags", {29'd0, update_done, ovf, bad_chan}, 32'd0);
    rstn = 1'b1;

    // Three writes, exact blank timing.
    clr_cnt();
    host_push(2'd0, 8'h10, 12'h123, 1'b1);
    host_push(2'd1, 8'h20, 12'h456, 1'b1);
    host_push(2'd2, 8'hFF, 12'hFFF, 1'b1);
    chk("t1_pending", {27'd0, pending}, 32'd3);
    @(posedge clk); #1 vsync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_we", {31'd0, lut_we}, {31'd0, (i >= 1 && i <= 3)});
      chk("t1_done", {31'd0, update_done}, {31'd0, (i == 5)});
    end
    @(posedge clk); #1 vsync = 1'b0;
    chk("t1_pending_end", {27'd0, pending}, 32'd0);

    // Overflow on the 17th push; clear has priority over a same-cycle set.
    clr_cnt();
    for (int i = 0; i < 16; i++) host_push(2'(i % 3), 8'(i * 7), 12'(i * 111), 1'b1);
    host_push(2'd0, 8'h55, 12'h555, 1'b0);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    chk("t2_full", {27'd0, pending}, 32'd16);
    @(posedge clk); #1 host_wr_valid = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1 host_wr_valid = 1'b0; err_clr = 1'b0;
    chk("t2_clr_prio", {31'd0, ovf}, 32'd0);
    blank(25);
    chk("t2_writes", we_cnt, 32'd16);
    chk("t2_done", done_cnt, 32'd1);
    chk("t2_pending", {27'd0, pending}, 32'd0);

    // Short blank leaves entries for the next one.
    clr_cnt();
    for (int i = 0; i < 16; i++) host_push(2'(2 - i % 3), 8'(255 - i), 12'(4095 - i * 13), 1'b1);
    blank(5);
    chk("t3_writes", we_cnt, 32'd4);
    chk("t3_pending", {27'd0, pending}, 32'd12);
    chk("t3_nodone", done_cnt, 32'd0);
    blank(20);
    chk("t3_writes2", we_cnt, 32'd16);
    chk("t3_done2", done_cnt, 32'd1);

    // Reserved channel entry is dropped and flagged.
    clr_cnt();
    host_push(2'd0, 8'h01, 12'hA01, 1'b1);
    host_push(2'd3, 8'h02, 12'hA02, 1'b1);
    host_push(2'd1, 8'h03, 12'hA03, 1'b1);
    blank(10);
    chk("t4_writes", we_cnt, 32'd2);
    chk("t4_bad", {31'd0, bad_chan}, 32'd1);
    chk("t4_pending", {27'd0, pending}, 32'd0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("t4_bad_clr", {31'd0, bad_chan}, 32'd0);

    // Late host write during DONE re-enters DRAIN.
    clr_cnt();
    host_push(2'd2, 8'h40, 12'h321, 1'b1);
    @(posedge clk); #1 vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    host_wr_valid = 1'b1; host_wr_chan = 2'd1; host_wr_addr = 8'h41; host_wr_data = 12'h654;
    sb.push_back({2'd1, 8'h41, 12'h654});
    @(posedge clk); #1 host_wr_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 vsync = 1'b0;
    chk("t5_writes", we_cnt, 32'd2);
    chk("t5_done", done_cnt, 32'd2);

    // de inside blank stalls the drain.
    clr_cnt();
    host_push(2'd0, 8'h77, 12'h777, 1'b1);
    host_push(2'd1, 8'h78, 12'h778, 1'b1);
    @(posedge clk); #1 vsync = 1'b1; de = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_stall", we_cnt, 32'd0);
    chk("t6_stall_pend", {27'd0, pending}, 32'd2);
    de = 1'b0;
    repeat (6) @(posedge clk);
    #1 vsync = 1'b0;
    chk("t6_writes", we_cnt, 32'd2);
    chk("t6_done", done_cnt, 32'd1);

    // Reset in the middle of a drain.
    clr_cnt();
    for (int i = 0; i < 8; i++) host_push(2'd1, 8'(i + 100), 12'(i + 200), 1'b1);
    @(posedge clk); #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("t7_pending", {27'd0, pending}, 32'd0);
    chk("t7_we", {31'd0, lut_we}, 32'd0);
    chk("t7_ready", {31'd0, host_wr_ready}, 32'd1);
    chk("t7_writes_before", we_cnt, 32'd2);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1 vsync = 1'b0;
    chk("t7_no_writes_after", we_cnt, 32'd2);
    chk("t7_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
